regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, clock; all state updates on the rising edge.
- rst_i, in, 1, asynchronous reset, active low.
- alu_valid_i / alu_ready_o, in/out, 1/1, ALU writeback request (requester 0) / grant.
- alu_rd_i / alu_data_i, in, 5/64, ALU destination register / data.
- lsu_valid_i / lsu_ready_o, in/out, 1/1, load-unit request (requester 1) / grant.
- lsu_rd_i / lsu_data_i, in, 5/64, load-unit destination / data.
- mdu_valid_i / mdu_ready_o, in/out, 1/1, mul/div request (requester 2) / grant.
- mdu_rd_i / mdu_data_i, in, 5/64, mul/div destination / data.
- issue_i / issue_rd_i, in, 1/5, decode issues an instruction that will write issue_rd_i.
- rs1_i / rs2_i, in, 5/5, source registers of the instruction in decode.
- stall_o, out, 1, decode must hold; the issue is ignored.
- busy_o, out, 32, scoreboard; bit n set means register n has a write pending.
- wr_reg_en_o / wr_rd_o / wr_data_o, out, 1/5/64, register-file write port.

Function
REQ-003 Handshake: a requester SHALL hold valid, rd and data stable until it sees ready; a transfer occurs on a cycle with valid and ready both high.
REQ-004 Ready SHALL be combinational from the valid inputs and the RR pointer, and at most one ready SHALL be high per cycle.
REQ-005 Arbitration SHALL be round-robin: priority starts at (last granted index + 1) mod 3; the pointer SHALL update only on a transfer.
REQ-006 When exactly one requester is valid, it SHALL be granted in that same cycle regardless of the pointer.
REQ-007 A transfer with rd != 0 SHALL register wr_reg_en_o=1 and the rd/data for exactly one cycle, giving a latency of 1 cycle.
REQ-008 A cycle with no transfer SHALL register wr_reg_en_o=0, and wr_rd_o/wr_data_o SHALL hold their previous values.
REQ-009 A transfer with rd == 0 SHALL be accepted (ready high, pointer advances), SHALL leave wr_reg_en_o at 0, and SHALL leave busy_o unchanged.
REQ-010 Scoreboard set: busy_o[issue_rd_i] SHALL be set on the edge where issue_i=1, stall_o=0 and issue_rd_i != 0.
REQ-011 Scoreboard clear: busy_o[rd] SHALL be cleared on the same edge that loads the write-port register for a transfer; the register file's same-cycle bypass then supplies the data.
REQ-012 If a set and a clear hit the same register on the same edge, the set SHALL win.
REQ-013 busy_o[0] SHALL always be 0.
REQ-014 stall_o SHALL be combinational and equal busy_o[rs1_i] | busy_o[rs2_i] | (issue_i & busy_o[issue_rd_i]).
REQ-015 A requester with valid high SHALL be granted within 3 cycles.
REQ-016 All three requesters SHALL be able to transfer back-to-back, one per cycle, with no idle cycles.

Reset
REQ-017 While rst_i=0 the block SHALL drive: busy_o=0, wr_reg_en_o=0, wr_rd_o=0, wr_data_o=0, all ready_o=0, and stall_o=0.
REQ-018 The reset value of the RR pointer SHALL be 2, so the ALU has first priority after reset.
REQ-019 Reset asserted mid-operation SHALL discard any in-flight write, clear all pending bits, and take effect without a clock edge.
REQ-020 Deassertion SHALL be synchronized; the first transfer SHALL occur no earlier than the first rising edge after deassertion.

Verification
REQ-021 Single write: alu_valid=1, rd=5, data=0xDEAD -> alu_ready=1 the same cycle; next cycle wr_reg_en_o=1, wr_rd_o=5, wr_data_o=0xDEAD; the cycle after, wr_reg_en_o=0.
REQ-022 Round-robin: after reset, hold all three valid (rd=1,2,3) -> grants in order ALU, LSU, MDU on consecutive cycles; wr_rd_o = 1, 2, 3 one cycle later each.
REQ-023 Scoreboard hazard: issue rd=7 -> busy_o[7]=1; rs1_i=7 -> stall_o=1; LSU writes rd=7 -> busy_o[7]=0 on the cycle wr_reg_en_o=1 and stall_o drops that cycle.
REQ-024 Collision: issue rd=9 on the same edge as the MDU transfer of rd=9 -> busy_o[9] remains 1.
REQ-025 x0: ALU transfer with rd=0 -> ready=1, wr_reg_en_o stays 0; issue rd=0 -> busy_o stays 0.
REQ-026 Mid-operation reset: pull rst_i low with busy_o=0x0000_00F0 and a write pending -> busy_o=0 and wr_reg_en_o=0 immediately, without a clock edge; the first grant after release goes to the ALU.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, decode-issue and register-file write-port signals for regfile_wb_arbiter.
// slave is the arbiter's view; master is the requester/decode/regfile side.
interface regfile_wb_arbiter_if;
   logic        alu_valid_i;
   logic        alu_ready_o;
   logic [4:0]  alu_rd_i;
   logic [63:0] alu_data_i;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic [4:0]  lsu_rd_i;
   logic [63:0] lsu_data_i;
   logic        mdu_valid_i;
   logic        mdu_ready_o;
   logic [4:0]  mdu_rd_i;
   logic [63:0] mdu_data_i;
   logic        issue_i;
   logic [4:0]  issue_rd_i;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic        stall_o;
   logic [31:0] busy_o;
   logic        wr_reg_en_o;
   logic [4:0]  wr_rd_o;
   logic [63:0] wr_data_o;

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i,
      input  mdu_valid_i, mdu_rd_i, mdu_data_i,
      input  issue_i, issue_rd_i, rs1_i, rs2_i,
      output alu_ready_o, lsu_ready_o, mdu_ready_o,
      output stall_o, busy_o, wr_reg_en_o, wr_rd_o, wr_data_o
   );

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      output lsu_valid_i, lsu_rd_i, lsu_data_i,
      output mdu_valid_i, mdu_rd_i, mdu_data_i,
      output issue_i, issue_rd_i, rs1_i, rs2_i,
      input  alu_ready_o, lsu_ready_o, mdu_ready_o,
      input  stall_o, busy_o, wr_reg_en_o, wr_rd_o, wr_data_o
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU/LSU/MDU) with register scoreboard; grant is same-cycle,
// write port is registered (1 cycle); losers are backpressured by ready low until their turn.
module regfile_wb_arbiter (
   input  logic                 clk_i,
   input  logic                 rst_i,
   regfile_wb_arbiter_if.slave  bus
);

   logic [1:0]  rst_sync_q, rst_sync_d;
   logic        active;
   logic [1:0]  ptr_q, ptr_d;
   logic [2:0]  vld, gnt;
   logic        xfer;
   logic [4:0]  sel_rd;
   logic [63:0] sel_data;
   logic        wr_en_q, wr_en_d;
   logic [4:0]  wr_rd_q, wr_rd_d;
   logic [63:0] wr_data_q, wr_data_d;
   logic [31:0] busy_q, busy_d;
   logic        stall;
   logic        issue_ok;

   // Release of reset is re-timed so no grant can appear before the first clean edge.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign active     = rst_sync_q[1];

   assign vld = {bus.mdu_valid_i, bus.lsu_valid_i, bus.alu_valid_i} & {3{active}};

   always_comb begin
      gnt = 3'b000;
      case (ptr_q)
         2'd0: begin
            if      (vld[1]) gnt = 3'b010;
            else if (vld[2]) gnt = 3'b100;
            else if (vld[0]) gnt = 3'b001;
         end
         2'd1: begin
            if      (vld[2]) gnt = 3'b100;
            else if (vld[0]) gnt = 3'b001;
            else if (vld[1]) gnt = 3'b010;
         end
         default: begin
            if      (vld[0]) gnt = 3'b001;
            else if (vld[1]) gnt = 3'b010;
            else if (vld[2]) gnt = 3'b100;
         end
      endcase
   end

   always_comb begin
      sel_rd   = 5'd0;
      sel_data = 64'd0;
      ptr_d    = ptr_q;
      if (gnt[0]) begin
         sel_rd   = bus.alu_rd_i;
         sel_data = bus.alu_data_i;
         ptr_d    = 2'd0;
      end else if (gnt[1]) begin
         sel_rd   = bus.lsu_rd_i;
         sel_data = bus.lsu_data_i;
         ptr_d    = 2'd1;
      end else if (gnt[2]) begin
         sel_rd   = bus.mdu_rd_i;
         sel_data = bus.mdu_data_i;
         ptr_d    = 2'd2;
      end
   end

   assign xfer = |gnt;

   assign stall = busy_q[bus.rs1_i] | busy_q[bus.rs2_i] |
                  (bus.issue_i & busy_q[bus.issue_rd_i]);
   assign issue_ok = bus.issue_i & ~stall & (bus.issue_rd_i != 5'd0);

   // Writes to x0 are accepted but never reach the register file or the scoreboard.
   always_comb begin
      wr_en_d   = xfer && (sel_rd != 5'd0);
      wr_rd_d   = wr_en_d ? sel_rd   : wr_rd_q;
      wr_data_d = wr_en_d ? sel_data : wr_data_q;
   end

   // Clear first, then set, so an issue colliding with a retiring write keeps the bit.
   always_comb begin
      busy_d = busy_q;
      if (wr_en_d)  busy_d[sel_rd]         = 1'b0;
      if (issue_ok) busy_d[bus.issue_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rst_sync_q <= 2'b00;
         ptr_q      <= 2'd2;
         wr_en_q    <= 1'b0;
         wr_rd_q    <= 5'd0;
         wr_data_q  <= 64'd0;
         busy_q     <= 32'd0;
      end else begin
         rst_sync_q <= rst_sync_d;
         ptr_q      <= ptr_d;
         wr_en_q    <= wr_en_d;
         wr_rd_q    <= wr_rd_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.alu_ready_o = gnt[0];
   assign bus.lsu_ready_o = gnt[1];
   assign bus.mdu_ready_o = gnt[2];
   assign bus.stall_o     = stall;
   assign bus.busy_o      = busy_q;
   assign bus.wr_reg_en_o = wr_en_q;
   assign bus.wr_rd_o     = wr_rd_q;
   assign bus.wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter: handshake, round-robin order, scoreboard, x0, async reset.
module tb_regfile_wb_arbiter;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [2:0] rdys();
      return {bus.mdu_ready_o, bus.lsu_ready_o, bus.alu_ready_o};
   endfunction

   initial begin
      logic [2:0] first_g;
      bus.alu_valid_i = 0; bus.alu_rd_i = 0; bus.alu_data_i = 0;
      bus.lsu_valid_i = 0; bus.lsu_rd_i = 0; bus.lsu_data_i = 0;
      bus.mdu_valid_i = 0; bus.mdu_rd_i = 0; bus.mdu_data_i = 0;
      bus.issue_i = 0; bus.issue_rd_i = 0; bus.rs1_i = 0; bus.rs2_i = 0;

      // Reset state
      #3;
      bus.alu_valid_i = 1;
      #1;
      chk("rst_busy",  bus.busy_o, 0);
      chk("rst_wren",  bus.wr_reg_en_o, 0);
      chk("rst_wrrd",  bus.wr_rd_o, 0);
      chk("rst_wrdat", bus.wr_data_o, 0);
      chk("rst_ready", rdys(), 3'b000);
      chk("rst_stall", bus.stall_o, 0);
      bus.alu_valid_i = 0;
      tick();
      rst_i = 1;
      tick(); tick(); tick();

      // Round-robin after reset: ALU, LSU, MDU
      bus.alu_valid_i = 1; bus.alu_rd_i = 1; bus.alu_data_i = 64'h11;
      bus.lsu_valid_i = 1; bus.lsu_rd_i = 2; bus.lsu_data_i = 64'h22;
      bus.mdu_valid_i = 1; bus.mdu_rd_i = 3; bus.mdu_data_i = 64'h33;
      #1;
      chk("rr_g0", rdys(), 3'b001);
      tick();
      bus.alu_valid_i = 0;
      #1;
      chk("rr_wr1", bus.wr_rd_o, 1);
      chk("rr_d1", bus.wr_data_o, 64'h11);
      chk("rr_g1", rdys(), 3'b010);
      tick();
      bus.lsu_valid_i = 0;
      #1;
      chk("rr_wr2", bus.wr_rd_o, 2);
      chk("rr_g2", rdys(), 3'b100);
      tick();
      bus.mdu_valid_i = 0;
      #1;
      chk("rr_wr3", {bus.wr_reg_en_o, 59'd0, bus.wr_rd_o}, {1'b1, 59'd0, 5'd3});
      chk("rr_d3", bus.wr_data_o, 64'h33);
      tick();

      // Single ALU write
      bus.alu_valid_i = 1; bus.alu_rd_i = 5; bus.alu_data_i = 64'hDEAD;
      #1;
      chk("sw_ready", rdys(), 3'b001);
      tick();
      bus.alu_valid_i = 0;
      #1;
      chk("sw_en", bus.wr_reg_en_o, 1);
      chk("sw_rd", bus.wr_rd_o, 5);
      chk("sw_data", bus.wr_data_o, 64'hDEAD);
      tick();
      chk("sw_en_off", bus.wr_reg_en_o, 0);
      chk("sw_hold", {bus.wr_rd_o, bus.wr_data_o}, {5'd5, 64'hDEAD});

      // Pointer at ALU: LSU beats ALU, then ALU
      bus.alu_valid_i = 1; bus.alu_rd_i = 4; bus.alu_data_i = 64'h44;
      bus.lsu_valid_i = 1; bus.lsu_rd_i = 6; bus.lsu_data_i = 64'h66;
      #1;
      chk("rr2_g0", rdys(), 3'b010);
      tick();
      bus.lsu_valid_i = 0;
      #1;
      chk("rr2_wr", bus.wr_rd_o, 6);
      chk("rr2_g1", rdys(), 3'b001);
      tick();
      bus.alu_valid_i = 0;
      #1;
      chk("rr2_wr2", bus.wr_rd_o, 4);
      tick();

      // Scoreboard hazard on x7
      bus.issue_i = 1; bus.issue_rd_i = 7;
      #1;
      chk("sb_nostall", bus.stall_o, 0);
      tick();
      bus.issue_i = 0;
      #1;
      chk("sb_set", bus.busy_o, 32'h80);
      bus.issue_i = 1; bus.issue_rd_i = 7;
      #1;
      chk("sb_waw_stall", bus.stall_o, 1);
      bus.issue_rd_i = 8; bus.rs1_i = 7;
      #1;
      chk("sb_raw_stall", bus.stall_o, 1);
      tick();
      bus.issue_i = 0;
      #1;
      chk("sb_stall_noset", bus.busy_o, 32'h80);
      bus.lsu_valid_i = 1; bus.lsu_rd_i = 7; bus.lsu_data_i = 64'h77;
      #1;
      chk("sb_lsu_g", rdys(), 3'b010);
      tick();
      bus.lsu_valid_i = 0;
      #1;
      chk("sb_clr_en", bus.wr_reg_en_o, 1);
      chk("sb_clr", bus.busy_o, 0);
      chk("sb_stall_drop", bus.stall_o, 0);
      bus.rs1_i = 0;

      // Collision: issue x9 on the MDU transfer edge of x9
      bus.mdu_valid_i = 1; bus.mdu_rd_i = 9; bus.mdu_data_i = 64'h99;
      bus.issue_i = 1; bus.issue_rd_i = 9;
      #1;
      chk("col_g", rdys(), 3'b100);
      chk("col_nostall", bus.stall_o, 0);
      tick();
      bus.mdu_valid_i = 0; bus.issue_i = 0;
      #1;
      chk("col_busy", bus.busy_o, 32'h200);
      chk("col_wr", {bus.wr_reg_en_o, 59'd0, bus.wr_rd_o}, {1'b1, 59'd0, 5'd9});
      bus.mdu_valid_i = 1;
      tick();
      bus.mdu_valid_i = 0;
      #1;
      chk("col_clr", bus.busy_o, 0);

      // x0 writes and issues
      bus.alu_valid_i = 1; bus.alu_rd_i = 0; bus.alu_data_i = 64'h55;
      bus.issue_i = 1; bus.issue_rd_i = 0;
      #1;
      chk("x0_ready", rdys(), 3'b001);
      tick();
      bus.alu_valid_i = 0; bus.issue_i = 0;
      #1;
      chk("x0_en", bus.wr_reg_en_o, 0);
      chk("x0_hold", {bus.wr_rd_o, bus.wr_data_o}, {5'd9, 64'h99});
      chk("x0_busy", bus.busy_o, 0);
      bus.alu_valid_i = 1; bus.alu_rd_i = 10;
      bus.lsu_valid_i = 1; bus.lsu_rd_i = 11;
      #1;
      chk("x0_ptr_adv", rdys(), 3'b010);
      bus.alu_valid_i = 0; bus.lsu_valid_i = 0;
      tick();

      // Mid-operation reset with x4..x7 pending and a write in flight
      for (int r = 4; r < 8; r++) begin
         bus.issue_i = 1; bus.issue_rd_i = r[4:0];
         tick();
      end
      bus.issue_i = 0;
      #1;
      chk("mr_pre_busy", bus.busy_o, 32'hF0);
      bus.alu_valid_i = 1; bus.alu_rd_i = 3; bus.alu_data_i = 64'hAB;
      tick();
      chk("mr_pre_wr", bus.wr_reg_en_o, 1);
      bus.lsu_valid_i = 1; bus.mdu_valid_i = 1;
      #1;
      rst_i = 0;
      #1;
      chk("mr_busy", bus.busy_o, 0);
      chk("mr_wren", bus.wr_reg_en_o, 0);
      chk("mr_ready", rdys(), 3'b000);
      #3;
      rst_i = 1;
      #1;
      chk("mr_rel_ready", rdys(), 3'b000);
      first_g = 3'b000;
      for (int c = 0; c < 6 && first_g == 3'b000; c++) begin
         tick();
         first_g = rdys();
      end
      chk("mr_first_grant", first_g, 3'b001);
      bus.alu_valid_i = 0; bus.lsu_valid_i = 0; bus.mdu_valid_i = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
